// File: rtl/ns_arb_pkg.sv
// Shared helpers for the ns arbiter slice:
// index width, one-hot decode and round-robin pick.
package ns_arb_pkg;

  localparam int NS_MAX = 64;
  localparam int NS_IW  = 6;

  function automatic int ns_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NS_IW-1:0] ns_oh2idx(
    input logic [NS_MAX-1:0] oh
  );
    logic [NS_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NS_MAX; i++)
      if (oh[i]) idx = idx | NS_IW'(i);
    return idx;
  endfunction

  // Search upward from ptr+1, wrapping modulo n; first set bit wins.
  function automatic logic [NS_MAX-1:0] ns_rr_pick(
    input logic [NS_MAX-1:0] req,
    input int unsigned       ptr,
    input int unsigned       n
  );
    logic [NS_MAX-1:0] g;
    logic [NS_IW-1:0]  idx;
    logic              found;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NS_MAX; k++) begin
      if (k <= n) begin
        idx = NS_IW'((ptr + k) % n);
        if (!found && req[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ns_mux1h.sv
// One-hot multiplexer: OR of the selected inputs.
// An all-zero select yields zero.
module ns_mux1h #(
  parameter int DATA_WIDTH = 3,
  parameter int SEL_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] data [SEL_WIDTH],
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < SEL_WIDTH; i++)
      if (sel[i]) y = y | data[i];
  end

endmodule

// File: rtl/ns_rr_arb_slice.sv
// Round-robin arbiter feeding a registered
// valid/ready output slice.
module ns_rr_arb_slice
  import ns_arb_pkg::*;
#(
  parameter int REQ_NUM    = 8,
  parameter int DATA_WIDTH = 3,
  localparam int SRC_W     = ns_idx_w(REQ_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_NUM-1:0]    req_vld,
  input  logic [DATA_WIDTH-1:0] req_data [REQ_NUM],
  output logic [REQ_NUM-1:0]    req_rdy,
  output logic [REQ_NUM-1:0]    grant_oh,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SRC_W-1:0]      out_src,
  input  logic                  out_rdy
);

  logic [SRC_W-1:0]      last_ptr;
  logic [NS_MAX-1:0]     pick;
  logic [SRC_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  load_en;
  logic                  any_req;

  always_comb begin
    pick     = ns_rr_pick(NS_MAX'(req_vld),
                          32'(last_ptr),
                          REQ_NUM);
    grant_oh = pick[REQ_NUM-1:0];
    win_idx  = SRC_W'(ns_oh2idx(pick));
    any_req  = |grant_oh;
    load_en  = !out_vld || out_rdy;
    req_rdy  = grant_oh & {REQ_NUM{load_en}};
  end

  ns_mux1h #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (REQ_NUM)
  ) u_mux (
    .data(req_data),
    .sel (grant_oh),
    .y   (win_data)
  );

  // Pointer moves only on accepted transfers, so a stalled
  // grant keeps its priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      last_ptr <= SRC_W'(REQ_NUM - 1);
    end else if (load_en) begin
      if (any_req) begin
        out_vld  <= 1'b1;
        out_data <= win_data;
        out_src  <= win_idx;
        last_ptr <= win_idx;
      end else begin
        out_vld  <= 1'b0;
      end
    end
  end

endmodule
